// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: host-side initiator for the convolution TPU core.
// Streams one job (kernel words, then matrix words) into the TPU. It then
// collects every TPU result into a small result FIFO and presents the FIFO
// as a valid/ready output stream.
module tpu_job_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int MATRIX_DIM = 16,
  parameter int CONV_DIM   = 3,
  parameter int RES_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  job_done,
  output logic                  tpu_insert_kernal,
  output logic                  tpu_write_mode,
  output logic                  tpu_write,
  output logic                  tpu_ready,
  output logic [DATA_WIDTH-1:0] tpu_data_in,
  input  logic                  tpu_done,
  input  logic [DATA_WIDTH-1:0] tpu_data_out
);

  localparam int CW = $clog2(MATRIX_DIM * MATRIX_DIM) + 1;
  localparam int AW = $clog2(RES_DEPTH);

  localparam logic [CW-1:0] K_LAST   = CW'(CONV_DIM * CONV_DIM - 1);
  localparam logic [CW-1:0] M_LAST   = CW'(MATRIX_DIM * MATRIX_DIM - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(RES_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_K  = 3'd1,
    ST_LOAD_M  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  state_t                state_r;
  logic [CW-1:0]         word_cnt_r;
  logic [CW-1:0]         res_cnt_r;
  logic                  job_done_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [RES_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           occ_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic in_hs_s;
  logic drain_last_s;

  // Full/empty come only from registered occupancy, so out_ready never
  // reaches tpu_ready combinationally.
  assign full_s  = (occ_r == OCC_FULL);
  assign empty_s = (occ_r == OCC_ZERO);
  assign push_s  = (state_r == ST_COMPUTE) && tpu_done && !full_s;
  assign pop_s   = !empty_s && out_ready;
  assign in_hs_s = in_valid && in_ready;

  // Finish when the FIFO is empty now or is emptied by this cycle's pop.
  // job_done then shows in the cycle right after the last pop.
  assign drain_last_s = (occ_r == OCC_ZERO) || ((occ_r == OCC_ONE) && pop_s);

  assign out_data  = fifo_mem_r[rd_ptr_r];
  assign out_valid = !empty_s;
  assign busy      = (state_r != ST_IDLE);
  assign job_done  = job_done_r;

  // TPU control decode. Load-phase data and strobes pass through with zero latency.
  always_comb begin
    in_ready          = 1'b0;
    tpu_insert_kernal = 1'b0;
    tpu_write_mode    = 1'b1;
    tpu_write         = 1'b0;
    tpu_ready         = 1'b0;
    tpu_data_in       = {DATA_WIDTH{1'b0}};
    case (state_r)
      ST_LOAD_K: begin
        in_ready          = 1'b1;
        tpu_insert_kernal = 1'b1;
        tpu_write         = in_valid;
        tpu_ready         = in_valid;
        tpu_data_in       = in_data;
      end
      ST_LOAD_M: begin
        in_ready    = 1'b1;
        tpu_write   = in_valid;
        tpu_data_in = in_data;
      end
      ST_COMPUTE: begin
        tpu_write_mode = 1'b0;
        tpu_ready      = !full_s;
      end
      default: begin
        tpu_write_mode = 1'b1;
      end
    endcase
  end

  // Job sequencing FSM with the word and result counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= CNT_ZERO;
      res_cnt_r  <= CNT_ZERO;
      job_done_r <= 1'b0;
    end else begin
      job_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Hold off a new start during the job_done cycle itself.
          if (start && !job_done_r) begin
            state_r    <= ST_LOAD_K;
            word_cnt_r <= CNT_ZERO;
          end
        end
        ST_LOAD_K: begin
          if (in_hs_s) begin
            if (word_cnt_r == K_LAST) begin
              state_r    <= ST_LOAD_M;
              word_cnt_r <= CNT_ZERO;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_ONE;
            end
          end
        end
        ST_LOAD_M: begin
          if (in_hs_s) begin
            if (word_cnt_r == M_LAST) begin
              state_r    <= ST_COMPUTE;
              word_cnt_r <= CNT_ZERO;
              res_cnt_r  <= CNT_ZERO;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_ONE;
            end
          end
        end
        ST_COMPUTE: begin
          if (push_s) begin
            if (res_cnt_r == M_LAST) begin
              state_r   <= ST_DRAIN;
              res_cnt_r <= CNT_ZERO;
            end else begin
              res_cnt_r <= res_cnt_r + CNT_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_last_s) begin
            state_r    <= ST_IDLE;
            job_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Result FIFO pointers and occupancy. A push and a pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      occ_r <= occ_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Result FIFO storage; the entries need no reset because occupancy qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= tpu_data_out;
    end
  end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Self-checking bench for tpu_job_sequencer (CONV_DIM=3, MATRIX_DIM=4).
// A table of job scenarios plus randomized jobs is checked against a
// queue-based reference. The bench acts as the TPU and presents results
// in order, advancing only when a result is accepted.
module tb_tpu_job_sequencer;

  localparam int DW = 16;
  localparam int MD = 4;
  localparam int CD = 3;
  localparam int RD = 4;
  localparam int NK = CD * CD;
  localparam int NM = MD * MD;
  localparam int NR = MD * MD;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          job_done;
  logic          tpu_insert_kernal;
  logic          tpu_write_mode;
  logic          tpu_write;
  logic          tpu_ready;
  logic [DW-1:0] tpu_data_in;
  logic          tpu_done;
  logic [DW-1:0] tpu_data_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tpu_job_sequencer #(
    .DATA_WIDTH(DW), .MATRIX_DIM(MD), .CONV_DIM(CD), .RES_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .job_done(job_done),
    .tpu_insert_kernal(tpu_insert_kernal), .tpu_write_mode(tpu_write_mode),
    .tpu_write(tpu_write), .tpu_ready(tpu_ready), .tpu_data_in(tpu_data_in),
    .tpu_done(tpu_done), .tpu_data_out(tpu_data_out)
  );

  typedef struct {
    int vld_mode;  // 0 always valid, 1 toggling, 2 random
    int rdy_mode;  // 0 out_ready high, 1 random
    int stall;     // cycles of out_ready=0 once compute starts
    int done_mode; // 0 tpu_done always, 1 random
    bit spam;      // pulse start while the job runs
    bit rnd;       // random data words
    int exp_k;
    int exp_m;
    int exp_r;
    int exp_done;
    int exp_peak;  // 0: only bounded by RD
    bit exp_ign;   // expect ignored tpu_done pulses
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_job(input vec_t v, input int id);
    logic [DW-1:0] kw [NK];
    logic [DW-1:0] mw [NM];
    logic [DW-1:0] rw [NR];
    logic [DW-1:0] kq [$];
    logic [DW-1:0] mq [$];
    logic [DW-1:0] oq [$];
    int widx = 0, ridx = 0, occ = 0, peak = 0, ign = 0, bad = 0;
    int ndone = 0, done_cyc = -1, last_pop = -1, comp_cyc = 0, busy_bad = 0;
    int errs = 0;
    bit seen = 1'b0;
    bit finished = 1'b0;
    string tag;
    tag = $sformatf("job%0d", id);
    for (int i = 0; i < NK; i++) kw[i] = v.rnd ? DW'($urandom) : DW'(i + 1);
    for (int i = 0; i < NM; i++) mw[i] = v.rnd ? DW'($urandom) : DW'(i + 1);
    for (int i = 0; i < NR; i++) rw[i] = v.rnd ? DW'($urandom) : DW'(16'h0100 + i);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tpu_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      in_data = (widx < NK) ? kw[widx] : (widx < NK + NM) ? mw[widx - NK] : 16'h0000;
      case (v.vld_mode)
        0:       in_valid = (widx < NK + NM);
        1:       in_valid = (widx < NK + NM) && cyc[0];
        default: in_valid = (widx < NK + NM) && ($urandom_range(0, 1) == 1);
      endcase
      if (seen && comp_cyc < v.stall) out_ready = 1'b0;
      else out_ready = (v.rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tpu_done     = (ridx < NR) && (v.done_mode == 0 || $urandom_range(0, 1) == 1);
      tpu_data_out = (ridx < NR) ? rw[ridx] : 16'h0000;
      start        = v.spam && (ridx < NR) && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (!tpu_write_mode) seen = 1'b1;
      if (seen) comp_cyc++;
      if (tpu_write) begin
        if (!in_valid || tpu_data_in !== in_data) bad++;
        if (tpu_insert_kernal) kq.push_back(tpu_data_in);
        else mq.push_back(tpu_data_in);
      end
      if (in_ready) begin
        if (tpu_insert_kernal ? (tpu_ready !== in_valid) : (tpu_ready !== 1'b0)) bad++;
      end
      if (in_valid && in_ready) widx++;
      if (out_valid !== (occ != 0)) bad++;
      if (!tpu_write_mode) begin
        if (tpu_ready !== (occ < RD)) bad++;
        if (tpu_done && !tpu_ready) ign++;
        if (tpu_done && tpu_ready) begin ridx++; occ++; end
      end
      if (out_valid && out_ready) begin
        oq.push_back(out_data);
        occ--;
        last_pop = cyc;
      end
      if (occ > peak) peak = occ;
      if (job_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) busy_bad++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; tpu_done = 1'b0; out_ready = 1'b1;
    chk({tag, " timeout"}, finished, 1);
    chk({tag, " kernel_strobes"}, kq.size(), v.exp_k);
    chk({tag, " matrix_strobes"}, mq.size(), v.exp_m);
    chk({tag, " results_out"}, oq.size(), v.exp_r);
    chk({tag, " job_done_pulses"}, ndone, v.exp_done);
    errs = 0;
    for (int i = 0; i < NK && i < kq.size(); i++) if (kq[i] !== kw[i]) errs++;
    for (int i = 0; i < NM && i < mq.size(); i++) if (mq[i] !== mw[i]) errs++;
    chk({tag, " load_data_errs"}, errs, 0);
    errs = 0;
    for (int i = 0; i < NR && i < oq.size(); i++) if (oq[i] !== rw[i]) errs++;
    chk({tag, " result_data_errs"}, errs, 0);
    chk({tag, " protocol_errs"}, bad, 0);
    chk({tag, " done_after_last_pop"}, done_cyc - last_pop, 1);
    chk({tag, " busy_during_done"}, busy_bad, 0);
    chk({tag, " peak_bounded"}, (peak <= RD), 1);
    if (v.exp_peak > 0) chk({tag, " peak_occupancy"}, peak, v.exp_peak);
    if (v.exp_ign) chk({tag, " ignored_done_seen"}, (ign > 0), 1);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_out_valid"}, out_valid, 0);
  endtask

  initial begin
    int w;
    int nd;
    vec_t rv;
    //          vld rdy stall done spam rnd  k   m   r  d peak ign
    tbl[0] = '{0,  0,  0,   0,   0,   0,   NK, NM, NR, 1, 1,   0};
    tbl[1] = '{1,  0,  0,   0,   0,   0,   NK, NM, NR, 1, 1,   0};
    tbl[2] = '{0,  0,  20,  0,   0,   0,   NK, NM, NR, 1, RD,  1};
    tbl[3] = '{0,  0,  8,   1,   0,   1,   NK, NM, NR, 1, 0,   0};
    tbl[4] = '{0,  0,  0,   0,   1,   0,   NK, NM, NR, 1, 1,   0};
    tbl[5] = '{2,  1,  0,   1,   1,   1,   NK, NM, NR, 1, 0,   0};

    rst = 1'b0; start = 1'b0; in_data = 16'h0000; in_valid = 1'b0;
    out_ready = 1'b1; tpu_done = 1'b0; tpu_data_out = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 16'h5a5a;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset job_done", job_done, 0);
    chk("reset tpu_write_mode", tpu_write_mode, 1);
    chk("reset tpu_write", tpu_write, 0);
    chk("reset tpu_ready", tpu_ready, 0);
    chk("reset tpu_insert_kernal", tpu_insert_kernal, 0);
    chk("reset tpu_data_in", tpu_data_in, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_job(tbl[i], i);

    for (int i = 0; i < 4; i++) begin
      rv = tbl[5];
      rv.stall = $urandom_range(0, 25);
      rv.spam  = ($urandom_range(0, 1) == 1);
      run_job(rv, 10 + i);
    end

    // Reset in the middle of the matrix load, after 7 matrix words.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; w = 0;
    for (int c = 0; c < 200 && w < NK + 7; c++) begin
      in_data = DW'(w + 1);
      @(negedge clk);
      if (in_valid && in_ready) w++;
      @(posedge clk); #1;
    end
    chk("midreset words_taken", w, NK + 7);
    @(negedge clk);
    chk("midreset busy_before", busy, 1);
    chk("midreset in_load_m", (in_ready && !tpu_insert_kernal), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset out_valid", out_valid, 0);
    chk("midreset tpu_write", tpu_write, 0);
    chk("midreset in_ready", in_ready, 0);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (job_done) nd++;
    end
    chk("midreset no_job_done", nd, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    run_job(tbl[0], 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
